// File: rtl/lfsr_pkg.sv
// Shared Galois LFSR helpers: one generic step function (up to 32 bits wide)
// and the standard tap masks used across the codebase.
package lfsr_pkg;

  localparam int unsigned MAX_WIDTH = 32;

  localparam logic [3:0]  POLY4  = 4'h3;
  localparam logic [7:0]  POLY8  = 8'h1D;
  localparam logic [15:0] POLY16 = 16'h002D;
  localparam logic [31:0] POLY32 = 32'h000000C5;

  typedef struct packed {
    logic                 fb;
    logic [MAX_WIDTH-1:0] next;
  } step_t;

  // Inputs are right-aligned; bits at or above width are zero on the way in and out.
  function automatic step_t lfsr_galois_step(input logic [MAX_WIDTH-1:0] state,
                                             input logic [MAX_WIDTH-1:0] poly,
                                             input int unsigned          width);
    step_t                res;
    logic [MAX_WIDTH-1:0] tap;
    logic [MAX_WIDTH-1:0] mask;
    tap      = 32'd1 << (width - 32'd1);
    mask     = (width >= 32'd32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    res.fb   = |(state & tap);
    res.next = ({state[MAX_WIDTH-2:0], 1'b0} ^ (res.fb ? poly : 32'd0)) & mask;
    return res;
  endfunction

endpackage

// File: rtl/lfsr_step_unroll.sv
// Combinational chain of STEPS Galois steps; exposes every intermediate
// state s1..sSTEPS (s_k at slice k-1) and the feedback bit of each step.
module lfsr_step_unroll
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH = 16,
  parameter logic [WIDTH-1:0] POLY  = 16'h002D,
  parameter int unsigned      STEPS = 1
) (
  input  logic [WIDTH-1:0]       state,
  output logic [STEPS*WIDTH-1:0] step_states,
  output logic [STEPS-1:0]       fb_bits
);

  logic [WIDTH-1:0] chain_s [0:STEPS];

  assign chain_s[0] = state;

  for (genvar k = 0; k < STEPS; k++) begin : g_step
    step_t                res_s;
    logic [MAX_WIDTH-1:0] unused_next_s;

    assign res_s                          = lfsr_galois_step(32'(chain_s[k]), 32'(POLY), WIDTH);
    assign chain_s[k+1]                   = res_s.next[WIDTH-1:0];
    assign fb_bits[k]                     = res_s.fb;
    assign step_states[k*WIDTH +: WIDTH]  = chain_s[k+1];
    // Bits above WIDTH are always zero from the step function.
    assign unused_next_s                  = res_s.next;
  end

endmodule

// File: rtl/lfsr_galois_multi.sv
// Parametrised multi-step Galois LFSR with seed load, all-zero lockup
// detection and period measurement against the loaded seed.
module lfsr_galois_multi
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH      = 16,
  parameter logic [WIDTH-1:0] POLY       = 16'h002D,
  parameter int unsigned      STEPS      = 1,
  parameter logic [WIDTH-1:0] RESET_SEED = 16'h0001
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             enable,
  output logic [WIDTH-1:0] state,
  output logic [STEPS-1:0] bits_out,
  output logic             lockup,
  output logic             period_done,
  output logic [WIDTH-1:0] period_len,
  output logic [WIDTH-1:0] step_count
);

  if (WIDTH < 32'd2 || WIDTH > 32'd32) begin : g_err_width
    $error("lfsr_galois_multi: WIDTH must be in 2..32");
  end
  if (POLY[0] != 1'b1) begin : g_err_poly
    $error("lfsr_galois_multi: POLY bit 0 must be 1");
  end
  if (STEPS < 32'd1 || STEPS > WIDTH) begin : g_err_steps
    $error("lfsr_galois_multi: STEPS must be in 1..WIDTH");
  end
  if (RESET_SEED == '0) begin : g_err_seed
    $error("lfsr_galois_multi: RESET_SEED must be nonzero");
  end

  localparam logic [WIDTH-1:0] STEPS_W = WIDTH'(STEPS);

  logic [WIDTH-1:0] state_r, state_n;
  logic [WIDTH-1:0] saved_seed_r, saved_seed_n;
  logic [WIDTH-1:0] step_count_r, step_count_n;
  logic [WIDTH-1:0] period_len_r, period_len_n;
  logic [STEPS-1:0] bits_out_r, bits_out_n;
  logic             lockup_r, lockup_n;
  logic             period_done_r, period_done_n;

  logic [STEPS*WIDTH-1:0] step_states_s;
  logic [STEPS-1:0]       fb_bits_s;
  logic                   match_s;
  logic [WIDTH-1:0]       match_pos_s;

  lfsr_step_unroll #(
    .WIDTH (WIDTH),
    .POLY  (POLY),
    .STEPS (STEPS)
  ) u_unroll (
    .state       (state_r),
    .step_states (step_states_s),
    .fb_bits     (fb_bits_s)
  );

  // Earliest step within this advance that lands back on the saved seed.
  always_comb begin
    match_s     = 1'b0;
    match_pos_s = '0;
    for (int unsigned k = 0; k < STEPS; k++) begin
      if (!match_s && (step_states_s[k*WIDTH +: WIDTH] == saved_seed_r)) begin
        match_s     = 1'b1;
        match_pos_s = WIDTH'(k + 32'd1);
      end else begin
        match_s     = match_s;
      end
    end
  end

  // Next-state selection: load beats enable; a locked-up LFSR never advances.
  always_comb begin
    state_n       = state_r;
    saved_seed_n  = saved_seed_r;
    step_count_n  = step_count_r;
    period_len_n  = period_len_r;
    bits_out_n    = bits_out_r;
    lockup_n      = lockup_r;
    period_done_n = 1'b0;
    if (load) begin
      state_n      = seed;
      saved_seed_n = seed;
      step_count_n = '0;
      bits_out_n   = '0;
      lockup_n     = (seed == '0);
    end else if (enable && !lockup_r) begin
      state_n    = step_states_s[(STEPS-1)*WIDTH +: WIDTH];
      bits_out_n = fb_bits_s;
      if (match_s) begin
        period_done_n = 1'b1;
        period_len_n  = step_count_r + match_pos_s;
        step_count_n  = STEPS_W - match_pos_s;
      end else begin
        step_count_n  = step_count_r + STEPS_W;
      end
    end else begin
      state_n = state_r;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r       <= RESET_SEED;
      saved_seed_r  <= RESET_SEED;
      step_count_r  <= '0;
      period_len_r  <= '0;
      bits_out_r    <= '0;
      lockup_r      <= 1'b0;
      period_done_r <= 1'b0;
    end else begin
      state_r       <= state_n;
      saved_seed_r  <= saved_seed_n;
      step_count_r  <= step_count_n;
      period_len_r  <= period_len_n;
      bits_out_r    <= bits_out_n;
      lockup_r      <= lockup_n;
      period_done_r <= period_done_n;
    end
  end

  assign state       = state_r;
  assign bits_out    = bits_out_r;
  assign lockup      = lockup_r;
  assign period_done = period_done_r;
  assign period_len  = period_len_r;
  assign step_count  = step_count_r;

endmodule
